// File: rtl/spi_slave_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_responder
// Brief    : SPI mode-0 slave; synchronized pins, MSB-first shift in/out.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_responder #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  sclk_i,
    input  logic                  cs_n_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    output logic                  tx_ack_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  busy_o
);

    localparam int                c_CNT_W = $clog2(DATA_WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [c_CNT_W-1:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_tx_shift, w_tx_shift_nxt;
    logic [DATA_WIDTH-1:0] r_rx_shift, w_rx_shift_nxt;
    logic [DATA_WIDTH-1:0] r_rx_data, w_rx_data_nxt;
    logic                  r_rx_valid, w_rx_valid_nxt;
    logic                  r_tx_ack, w_tx_ack_nxt;

    logic r_sclk_meta, r_sclk_sync, r_sclk_d;
    logic r_cs_meta, r_cs_sync, r_cs_d;
    logic r_mosi_meta, r_mosi_sync;
    logic [1:0] r_fill;
    logic r_cs_armed;

    logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
    logic [DATA_WIDTH-1:0] w_rx_word;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_d    <= 1'b0;
            r_cs_meta   <= 1'b1;
            r_cs_sync   <= 1'b1;
            r_cs_d      <= 1'b1;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
            r_fill      <= 2'b00;
            r_cs_armed  <= 1'b0;
        end else begin
            r_sclk_meta <= sclk_i;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_d    <= r_sclk_sync;
            r_cs_meta   <= cs_n_i;
            r_cs_sync   <= r_cs_meta;
            r_cs_d      <= r_cs_sync;
            r_mosi_meta <= mosi_i;
            r_mosi_sync <= r_mosi_meta;
            r_fill      <= {r_fill[0], 1'b1};
            // Only accept a cs_n fall once the real pin has been seen high, so a
            // transfer already running at reset release is not joined mid-way.
            r_cs_armed  <= r_cs_armed | (r_fill[1] & r_cs_sync);
        end
    end

    assign w_sclk_rise = r_sclk_sync & ~r_sclk_d;
    assign w_sclk_fall = ~r_sclk_sync & r_sclk_d;
    assign w_cs_fall   = ~r_cs_sync & r_cs_d & r_cs_armed;
    assign w_cs_rise   = r_cs_sync & ~r_cs_d;
    assign w_rx_word   = {r_rx_shift[DATA_WIDTH-2:0], r_mosi_sync};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_tx_ack   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_tx_ack   <= w_tx_ack_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_tx_shift_nxt = r_tx_shift;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_tx_ack_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_tx_shift_nxt = tx_data_i;
                    w_tx_ack_nxt   = 1'b1;
                    w_bit_cnt_nxt  = '0;
                    w_state_nxt    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_cs_rise) begin
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = ST_IDLE;
                end else if (w_sclk_rise) begin
                    w_rx_shift_nxt = w_rx_word;
                    if (r_bit_cnt == c_LAST) begin
                        w_rx_data_nxt  = w_rx_word;
                        w_rx_valid_nxt = 1'b1;
                        w_bit_cnt_nxt  = '0;
                        w_tx_shift_nxt = tx_data_i;
                        w_tx_ack_nxt   = 1'b1;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end else if (w_sclk_fall && (r_bit_cnt != '0)) begin
                    // No shift at bit 0: the word just loaded keeps its MSB on the wire.
                    w_tx_shift_nxt = {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign busy_o     = (r_state == ST_SHIFT);
    assign miso_o     = (r_state == ST_SHIFT) & r_tx_shift[DATA_WIDTH-1];
    assign tx_ack_o   = r_tx_ack;
    assign rx_data_o  = r_rx_data;
    assign rx_valid_o = r_rx_valid;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_responder
// Brief    : Directed bench for the SPI responder at 8- and 16-bit word sizes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        sel = 1'b0;
    logic [15:0] tx_data = '0;

    logic        sclk8, cs_n8, miso8, tx_ack8, rx_valid8, busy8;
    logic [7:0]  rx_data8;
    logic        sclk16, cs_n16, miso16, tx_ack16, rx_valid16, busy16;
    logic [15:0] rx_data16;
    logic        miso;

    int total = 0;
    int bad = 0;
    int rxv8 = 0, ack8 = 0, rxv16 = 0, ack16 = 0;
    logic [7:0] rxlog8 [16];

    assign sclk8  = sel ? 1'b0 : sclk;
    assign cs_n8  = sel ? 1'b1 : cs_n;
    assign sclk16 = sel ? sclk : 1'b0;
    assign cs_n16 = sel ? cs_n : 1'b1;
    assign miso   = sel ? miso16 : miso8;

    always #5 clk = ~clk;

    spi_slave_responder #(.DATA_WIDTH(8)) u_dut8 (
        .clk_i(clk), .rst_n_i(rst_n), .sclk_i(sclk8), .cs_n_i(cs_n8),
        .mosi_i(mosi), .miso_o(miso8), .tx_data_i(tx_data[7:0]),
        .tx_ack_o(tx_ack8), .rx_data_o(rx_data8), .rx_valid_o(rx_valid8),
        .busy_o(busy8)
    );

    spi_slave_responder #(.DATA_WIDTH(16)) u_dut16 (
        .clk_i(clk), .rst_n_i(rst_n), .sclk_i(sclk16), .cs_n_i(cs_n16),
        .mosi_i(mosi), .miso_o(miso16), .tx_data_i(tx_data),
        .tx_ack_o(tx_ack16), .rx_data_o(rx_data16), .rx_valid_o(rx_valid16),
        .busy_o(busy16)
    );

    always @(posedge clk) begin
        if (rx_valid8) begin
            rxlog8[rxv8[3:0]] <= rx_data8;
            rxv8 <= rxv8 + 1;
        end
        if (tx_ack8)    ack8  <= ack8 + 1;
        if (rx_valid16) rxv16 <= rxv16 + 1;
        if (tx_ack16)   ack16 <= ack16 + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Mode-0 master: data set during SCLK low, sampled on the rising edge.
    task automatic xfer_bits(input logic [15:0] tx, input int n, output logic [15:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            mosi = tx[n-1-i];
            tick(6);
            sclk = 1'b1;
            rx = {rx[14:0], miso};
            tick(6);
            sclk = 1'b0;
        end
    endtask

    initial begin
        logic [15:0] m, m1, m2;
        int rxv_s, ack_s;

        // Reset held with cs_n low and SCLK toggling
        rst_n = 1'b0;
        cs_n  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(3); sclk = 1'b1; tick(3); sclk = 1'b0;
        end
        check("rst_miso", {31'd0, miso8}, 32'd0);
        check("rst_busy", {31'd0, busy8}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data8}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid8}, 32'd0);
        check("rst_tx_ack", {31'd0, tx_ack8}, 32'd0);
        rst_n = 1'b1;
        xfer_bits(16'h00FF, 8, m);
        tick(6);
        check("rst_no_join_rxv", rxv8, 0);
        check("rst_no_join_ack", ack8, 0);
        check("rst_no_join_busy", {31'd0, busy8}, 32'd0);
        cs_n = 1'b1;
        tick(8);

        // Single word: send A5, expect 3C back
        tx_data = 16'h003C;
        rxv_s = rxv8; ack_s = ack8;
        cs_n = 1'b0;
        tick(6);
        check("single_busy", {31'd0, busy8}, 32'd1);
        check("single_miso_msb", {31'd0, miso8}, 32'd0);
        xfer_bits(16'h00A5, 8, m);
        tick(6);
        check("single_rx_data", {24'd0, rx_data8}, 32'hA5);
        check("single_rxv_cnt", rxv8 - rxv_s, 1);
        check("single_master_rx", {16'd0, m}, 32'h3C);
        cs_n = 1'b1;
        tick(6);
        check("single_busy_end", {31'd0, busy8}, 32'd0);
        check("single_ack_cnt", ack8 - ack_s, 2);

        // Abort after 3 bits of FF
        rxv_s = rxv8;
        cs_n = 1'b0;
        tick(6);
        xfer_bits(16'h0007, 3, m);
        cs_n = 1'b1;
        tick(6);
        check("abort_rx_data", {24'd0, rx_data8}, 32'hA5);
        check("abort_rxv_cnt", rxv8 - rxv_s, 0);
        check("abort_busy", {31'd0, busy8}, 32'd0);
        check("abort_miso", {31'd0, miso8}, 32'd0);

        // Back-to-back with cs_n held low
        tx_data = 16'h00F0;
        rxv_s = rxv8; ack_s = ack8;
        cs_n = 1'b0;
        tick(6);
        check("b2b_first_ack", ack8 - ack_s, 1);
        tx_data = 16'h000F;
        xfer_bits(16'h0081, 8, m1);
        xfer_bits(16'h007E, 8, m2);
        tick(6);
        cs_n = 1'b1;
        tick(6);
        check("b2b_rxv_cnt", rxv8 - rxv_s, 2);
        check("b2b_word0", {24'd0, rxlog8[rxv_s[3:0]]}, 32'h81);
        check("b2b_word1", {24'd0, rxlog8[4'(rxv_s + 1)]}, 32'h7E);
        check("b2b_miso0", {16'd0, m1}, 32'hF0);
        check("b2b_miso1", {16'd0, m2}, 32'h0F);
        check("b2b_ack_cnt", ack8 - ack_s, 3);

        // Reset in the middle of a word
        rxv_s = rxv8;
        cs_n = 1'b0;
        tick(6);
        xfer_bits(16'h001F, 5, m);
        rst_n = 1'b0;
        tick(2);
        check("midrst_rx_data", {24'd0, rx_data8}, 32'd0);
        check("midrst_busy", {31'd0, busy8}, 32'd0);
        check("midrst_miso", {31'd0, miso8}, 32'd0);
        rst_n = 1'b1;
        xfer_bits(16'h00FF, 8, m);
        tick(6);
        check("midrst_no_rxv", rxv8 - rxv_s, 0);
        cs_n = 1'b1;
        tick(8);
        cs_n = 1'b0;
        tick(6);
        xfer_bits(16'h005A, 8, m);
        tick(6);
        cs_n = 1'b1;
        tick(6);
        check("midrst_rx_5a", {24'd0, rx_data8}, 32'h5A);
        check("midrst_rxv_cnt", rxv8 - rxv_s, 1);

        // 16-bit instance
        sel = 1'b1;
        tx_data = 16'h1234;
        rxv_s = rxv16; ack_s = ack16;
        tick(4);
        cs_n = 1'b0;
        tick(6);
        check("w16_busy", {31'd0, busy16}, 32'd1);
        xfer_bits(16'hBEEF, 16, m);
        tick(6);
        cs_n = 1'b1;
        tick(6);
        check("w16_rx_data", {16'd0, rx_data16}, 32'hBEEF);
        check("w16_rxv_cnt", rxv16 - rxv_s, 1);
        check("w16_master_rx", {16'd0, m}, 32'h1234);
        check("w16_ack_cnt", ack16 - ack_s, 2);
        check("w16_busy_end", {31'd0, busy16}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
